// File: rtl/seg_char_buffer.sv
// 7-segment character buffer: push/backspace/clear with delayed commit and reject/scroll full policy.
// Optional blinking cursor on the next free slot's dp bit when SEG_CURSOR_EN is defined.
module seg_char_buffer #(
    parameter int DIGITS       = 8,
    parameter int COMMIT_DELAY = 1000000,
    parameter int SCROLL_MODE  = 0,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_btn,
    input  logic                          bs_btn,
    input  logic                          clr,
    input  logic [4:0]                    code,
    output logic [DIGITS*8-1:0]           seg_out,
    output logic [$clog2(DIGITS+1)-1:0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          busy
);

    localparam int W  = DIGITS * 8;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int DW = $clog2(COMMIT_DELAY + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   dly_reg, dly_next;
    logic [W-1:0]    buf_reg, buf_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            push_q_reg, bs_q_reg;
    logic            push_pe, bs_pe, commit;

    function automatic logic [7:0] enc(input logic [4:0] c);
        logic [7:0] s;
        case (c)
            5'h00: s = 8'hC0;  5'h01: s = 8'hF9;  5'h02: s = 8'hA4;  5'h03: s = 8'hB0;
            5'h04: s = 8'h99;  5'h05: s = 8'h92;  5'h06: s = 8'h82;  5'h07: s = 8'hF8;
            5'h08: s = 8'h80;  5'h09: s = 8'h90;  5'h0A: s = 8'h88;  5'h0B: s = 8'h83;
            5'h0C: s = 8'hC6;  5'h0D: s = 8'hA1;  5'h0E: s = 8'h86;  5'h0F: s = 8'h8E;
            5'h10: s = 8'hBF;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign push_pe = push_btn & ~push_q_reg;
    assign bs_pe   = bs_btn & ~bs_q_reg;
    assign full    = (count_reg == CW'(DIGITS));
    assign empty   = (count_reg == '0);
    assign busy    = (state_reg == WAIT);
    assign count   = count_reg;

    always_comb begin
        state_next = state_reg;
        dly_next   = dly_reg;
        buf_next   = buf_reg;
        count_next = count_reg;
        commit     = 1'b0;
        if (clr) begin
            state_next = IDLE;
            dly_next   = '0;
            buf_next   = '1;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (push_pe && (!full || SCROLL_MODE != 0)) begin
                        state_next = WAIT;
                        dly_next   = '0;
                    end
                end
                WAIT: begin
                    if (dly_reg == DW'(COMMIT_DELAY - 1)) begin
                        commit     = 1'b1;
                        state_next = IDLE;
                        dly_next   = '0;
                    end else begin
                        dly_next = dly_reg + DW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
            // A backspace landing on the commit edge is dropped.
            if (commit) begin
                buf_next = {buf_reg[W-9:0], enc(code)};
                if (!full)
                    count_next = count_reg + CW'(1);
            end else if (bs_pe && !empty) begin
                buf_next   = {8'hFF, buf_reg[W-1:8]};
                count_next = count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            dly_reg    <= '0;
            buf_reg    <= '1;
            count_reg  <= '0;
            // Edge registers follow the buttons during reset so a held button
            // produces no pulse until it is released and pressed again.
            push_q_reg <= push_btn;
            bs_q_reg   <= bs_btn;
        end else begin
            state_reg  <= state_next;
            dly_reg    <= dly_next;
            buf_reg    <= buf_next;
            count_reg  <= count_next;
            push_q_reg <= push_btn;
            bs_q_reg   <= bs_btn;
        end
    end

`ifdef SEG_CURSOR_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    logic [BW-1:0] blink_reg;
    logic          flag_reg;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            blink_reg <= '0;
            flag_reg  <= 1'b0;
        end else if (blink_reg == BW'(BLINK_DIV - 1)) begin
            blink_reg <= '0;
            flag_reg  <= ~flag_reg;
        end else begin
            blink_reg <= blink_reg + BW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cursor
            assign seg_out[gi*8+7]    = buf_reg[gi*8+7] &
                                        ~(flag_reg && !full && count_reg == CW'(gi));
            assign seg_out[gi*8+6 -: 7] = buf_reg[gi*8+6 -: 7];
        end
    endgenerate
`else
    assign seg_out = buf_reg;
`endif

endmodule

// File: tb/tb_seg_char_buffer.sv
// Directed bench: a reject-mode and a scroll-mode instance share stimulus and are
// checked against hand-computed segment/count tables plus multi-cycle corner sequences.
module tb_seg_char_buffer;

    localparam int D  = 4;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst, push_btn, bs_btn, clr;
    logic [4:0]  code;
    logic [31:0] seg_r, seg_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        full_r, empty_r, busy_r, full_s, empty_s, busy_s;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seg_char_buffer #(.DIGITS(D), .COMMIT_DELAY(CD), .SCROLL_MODE(0), .BLINK_DIV(8)) dut_rej (
        .clk(clk), .rst(rst), .push_btn(push_btn), .bs_btn(bs_btn), .clr(clr), .code(code),
        .seg_out(seg_r), .count(cnt_r), .full(full_r), .empty(empty_r), .busy(busy_r));

    seg_char_buffer #(.DIGITS(D), .COMMIT_DELAY(CD), .SCROLL_MODE(1), .BLINK_DIV(8)) dut_scr (
        .clk(clk), .rst(rst), .push_btn(push_btn), .bs_btn(bs_btn), .clr(clr), .code(code),
        .seg_out(seg_s), .count(cnt_s), .full(full_s), .empty(empty_s), .busy(busy_s));

    typedef enum int {OP_PUSH, OP_BS, OP_CLR} op_t;
    typedef struct {
        op_t         op;
        logic [4:0]  code;
        logic [31:0] seg_rej;
        logic [2:0]  cnt_rej;
        logic [31:0] seg_scr;
        logic [2:0]  cnt_scr;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Press push for one cycle and step through the commit delay, checking busy each cycle.
    task automatic do_push(input logic [4:0] c, input logic exp_busy_r);
        code     = c;
        push_btn = 1'b1;
        tick();
        push_btn = 1'b0;
        for (int k = 0; k < CD; k++) begin
            chk("busy_rej_wait", 32'(busy_r), 32'(exp_busy_r));
            chk("busy_scr_wait", 32'(busy_s), 32'd1);
            tick();
        end
        chk("busy_rej_after", 32'(busy_r), 32'd0);
        chk("busy_scr_after", 32'(busy_s), 32'd0);
    endtask

    task automatic check_rej(input string tag, input logic [31:0] s, input logic [2:0] c);
        chk({tag, "_seg"},   seg_r, s);
        chk({tag, "_count"}, 32'(cnt_r), 32'(c));
        chk({tag, "_full"},  32'(full_r), 32'(c == 3'd4));
        chk({tag, "_empty"}, 32'(empty_r), 32'(c == 3'd0));
    endtask

    initial begin
        logic [2:0] prev_cnt;

        vecs[0]  = '{OP_PUSH, 5'h01, 32'hFFFFFFF9, 3'd1, 32'hFFFFFFF9, 3'd1};
        vecs[1]  = '{OP_PUSH, 5'h02, 32'hFFFFF9A4, 3'd2, 32'hFFFFF9A4, 3'd2};
        vecs[2]  = '{OP_PUSH, 5'h03, 32'hFFF9A4B0, 3'd3, 32'hFFF9A4B0, 3'd3};
        vecs[3]  = '{OP_PUSH, 5'h04, 32'hF9A4B099, 3'd4, 32'hF9A4B099, 3'd4};
        vecs[4]  = '{OP_PUSH, 5'h10, 32'hF9A4B099, 3'd4, 32'hA4B099BF, 3'd4};
        vecs[5]  = '{OP_BS,   5'h00, 32'hFFF9A4B0, 3'd3, 32'hFFA4B099, 3'd3};
        vecs[6]  = '{OP_BS,   5'h00, 32'hFFFFF9A4, 3'd2, 32'hFFFFA4B0, 3'd2};
        vecs[7]  = '{OP_CLR,  5'h00, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, 3'd0};
        vecs[8]  = '{OP_BS,   5'h00, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, 3'd0};
        vecs[9]  = '{OP_PUSH, 5'h11, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 3'd1};
        vecs[10] = '{OP_PUSH, 5'h0A, 32'hFFFFFF88, 3'd2, 32'hFFFFFF88, 3'd2};
        vecs[11] = '{OP_PUSH, 5'h0F, 32'hFFFF888E, 3'd3, 32'hFFFF888E, 3'd3};
        vecs[12] = '{OP_PUSH, 5'h0C, 32'hFF888EC6, 3'd4, 32'hFF888EC6, 3'd4};

        rst = 1'b0; push_btn = 1'b0; bs_btn = 1'b0; clr = 1'b0; code = 5'h00;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();

        check_rej("reset", 32'hFFFFFFFF, 3'd0);
        chk("reset_busy", 32'(busy_r), 32'd0);
        chk("reset_seg_scr", seg_s, 32'hFFFFFFFF);
        $display("[TB] reset seg=%h count=%0d", seg_r, cnt_r);

        prev_cnt = 3'd0;
        for (int i = 0; i < 13; i++) begin
            case (vecs[i].op)
                OP_PUSH: do_push(vecs[i].code, prev_cnt != 3'd4);
                OP_BS: begin
                    bs_btn = 1'b1; tick(); bs_btn = 1'b0; tick();
                end
                default: begin
                    clr = 1'b1; tick(); clr = 1'b0; tick();
                end
            endcase
            check_rej($sformatf("vec%0d_rej", i), vecs[i].seg_rej, vecs[i].cnt_rej);
            chk($sformatf("vec%0d_scr_seg", i), seg_s, vecs[i].seg_scr);
            chk($sformatf("vec%0d_scr_count", i), 32'(cnt_s), 32'(vecs[i].cnt_scr));
            $display("[TB] vec %0d op=%0d code=%h rej=%h/%0d scr=%h/%0d",
                     i, vecs[i].op, vecs[i].code, seg_r, cnt_r, seg_s, cnt_s);
            prev_cnt = vecs[i].cnt_rej;
        end

        // Backspace during a pending push: push of 3 still commits afterwards.
        clr = 1'b1; tick(); clr = 1'b0; tick();
        do_push(5'h01, 1'b1);
        do_push(5'h02, 1'b1);
        code = 5'h03; push_btn = 1'b1; tick(); push_btn = 1'b0;
        tick();
        bs_btn = 1'b1; tick(); bs_btn = 1'b0;
        check_rej("bs_wait_mid", 32'hFFFFFFF9, 3'd1);
        chk("bs_wait_busy", 32'(busy_r), 32'd1);
        tick(); tick();
        check_rej("bs_wait_commit", 32'hFFFFF9B0, 3'd2);
        chk("bs_wait_busy_end", 32'(busy_r), 32'd0);
        $display("[TB] bs-during-wait seg=%h count=%0d", seg_r, cnt_r);

        // Backspace on the commit edge is dropped.
        code = 5'h04; push_btn = 1'b1; tick(); push_btn = 1'b0;
        tick(); tick(); tick();
        bs_btn = 1'b1; tick(); bs_btn = 1'b0;
        check_rej("bs_commit", 32'hFFF9B099, 3'd3);
        tick();
        check_rej("bs_commit_hold", 32'hFFF9B099, 3'd3);
        $display("[TB] bs-on-commit seg=%h count=%0d", seg_r, cnt_r);

        // Clear in the middle of a pending push cancels it.
        code = 5'h05; push_btn = 1'b1; tick(); push_btn = 1'b0;
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check_rej("clr_wait", 32'hFFFFFFFF, 3'd0);
        chk("clr_wait_busy", 32'(busy_r), 32'd0);
        for (int k = 0; k < CD + 2; k++) tick();
        check_rej("clr_no_commit", 32'hFFFFFFFF, 3'd0);
        $display("[TB] clr-mid-wait seg=%h count=%0d", seg_r, cnt_r);

        // Push held across reset produces no pulse until re-pressed.
        code = 5'h07; push_btn = 1'b1;
        rst = 1'b0; tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_busy", 32'(busy_r), 32'd0);
        end
        push_btn = 1'b0; tick();
        do_push(5'h07, 1'b1);
        check_rej("repress", 32'hFFFFFFF8, 3'd1);
        $display("[TB] held-across-reset seg=%h count=%0d", seg_r, cnt_r);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
